// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings and default widths for the IF/MEM port arbiter.
// Imported by mem_port_arbiter and mem_arb_perf (optional MEM_ARB_PERF_EN build).
package mem_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int PERF_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_perf.sv
// mem_arb_perf: stall-cycle and completed-transaction counters for the arbiter.
// Only instantiated when MEM_ARB_PERF_EN is defined; counters wrap naturally.
module mem_arb_perf
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_stall_if,
    input  logic              i_stall_mem,
    input  logic              i_xfer_done,
    output logic [PERF_W-1:0] o_perf_i_wait,
    output logic [PERF_W-1:0] o_perf_d_wait,
    output logic [PERF_W-1:0] o_perf_xfers
);

    logic [PERF_W-1:0] r_i_wait;
    logic [PERF_W-1:0] r_d_wait;
    logic [PERF_W-1:0] r_xfers;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i_wait <= '0;
            r_d_wait <= '0;
            r_xfers  <= '0;
        end else begin
            if (i_stall_if) begin
                r_i_wait <= r_i_wait + 1'b1;
            end
            if (i_stall_mem) begin
                r_d_wait <= r_d_wait + 1'b1;
            end
            if (i_xfer_done) begin
                r_xfers <= r_xfers + 1'b1;
            end
        end
    end

    assign o_perf_i_wait = r_i_wait;
    assign o_perf_d_wait = r_d_wait;
    assign o_perf_xfers  = r_xfers;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF fetches and MEM loads/stores.
// Define MEM_ARB_PERF_EN to add the perf_i_wait/perf_d_wait/perf_xfers counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              stall_if,
    output logic              stall_mem
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_i_wait,
    output logic [PERF_W-1:0] perf_d_wait,
    output logic [PERF_W-1:0] perf_xfers
`endif
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    arb_owner_t        r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic w_take_d;
    logic w_take_i;
    logic w_hs;
    logic w_wr_done;
    logic w_rd_done;

    // MEM wins ties: the instruction in MEM is older than the one being fetched
    assign w_take_d  = (r_state == ST_IDLE) && d_req;
    assign w_take_i  = (r_state == ST_IDLE) && !d_req && i_req;
    assign w_hs      = (r_state == ST_ISSUE) && m_ready;
    assign w_wr_done = w_hs && r_we;
    assign w_rd_done = (r_state == ST_WAIT) && m_rvalid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (d_req || i_req) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (m_ready) begin
                    w_state_nxt = r_we ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (m_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner <= OWN_I;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_take_d) begin
            r_owner <= OWN_D;
            r_we    <= d_we;
            r_addr  <= d_addr;
            r_wdata <= d_wdata;
        end else if (w_take_i) begin
            r_owner <= OWN_I;
            r_we    <= 1'b0;
            r_addr  <= i_addr;
        end
    end

    // a done is never pulsed to a requester that has already let go of req
    always_comb begin
        m_req    = 1'b0;
        m_we     = 1'b0;
        i_rvalid = 1'b0;
        d_done   = 1'b0;
        unique case (r_state)
            ST_ISSUE: begin
                m_req  = 1'b1;
                m_we   = r_we;
                d_done = w_wr_done && d_req;
            end
            ST_WAIT: begin
                i_rvalid = w_rd_done && (r_owner == OWN_I) && i_req;
                d_done   = w_rd_done && (r_owner == OWN_D) && d_req;
            end
            default: begin
                m_req = 1'b0;
            end
        endcase
    end

    assign m_addr    = r_addr;
    assign m_wdata   = r_wdata;
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;
    assign stall_if  = i_req & ~i_rvalid;
    assign stall_mem = d_req & ~d_done;

`ifdef MEM_ARB_PERF_EN
    logic w_xfer_done;

    assign w_xfer_done = w_wr_done || w_rd_done;

    mem_arb_perf u_perf (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_stall_if    (stall_if),
        .i_stall_mem   (stall_mem),
        .i_xfer_done   (w_xfer_done),
        .o_perf_i_wait (perf_i_wait),
        .o_perf_d_wait (perf_d_wait),
        .o_perf_xfers  (perf_xfers)
    );
`endif

endmodule
